sub_seq_ctrl: RTL and testbench

//  Byte-serial multi-precision subtract sequencer. Computes DIFF = A - B - bin on

---
 rtl/sub_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_sub_seq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sub_seq_ctrl.sv
// rtl/sub_seq_ctrl.sv - byte-serial multi-precision subtract sequencer
//
// Computes diff = a - b - bin over NBYTES-byte operands, one byte per clock,
// LSB first, through a single 8-bit subtract datapath with byte-to-byte borrow.
// Optional feature macro: SUB_SEQ_ZERO_FLAG_EN (adds the zero output).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operands valid
//   in_ready   out  sequencer idle and able to accept operands
//   a, b       in   minuend / subtrahend, 8*NBYTES bits
//   bin        in   borrow-in to byte 0
//   out_valid  out  result valid (held until out_ready)
//   out_ready  in   consumer accepts result
//   diff       out  a - b - bin mod 2^W
//   bout       out  final borrow
//   overflow   out  signed overflow of the full-width subtract
//   busy       out  high while bytes are being processed
//   zero       out  diff == 0 (only with SUB_SEQ_ZERO_FLAG_EN)

module sub_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   diff,
    output logic                  bout,
    output logic                  overflow,
`ifdef SUB_SEQ_ZERO_FLAG_EN
    output logic                  zero,
`endif
    output logic                  busy
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state_q,    state_d;
    logic [IDXW-1:0] idx_q,      idx_d;
    logic [W-1:0]    a_q,        a_d;
    logic [W-1:0]    b_q,        b_d;
    logic            borrow_q,   borrow_d;
    logic [W-1:0]    diff_q,     diff_d;
    logic            bout_q,     bout_d;
    logic            overflow_q, overflow_d;
`ifdef SUB_SEQ_ZERO_FLAG_EN
    logic            zero_acc_q, zero_acc_d;
    logic            zero_q,     zero_d;
`endif

    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic [8:0] d9;

    // in_ready is held low while reset is asserted so nothing is accepted
    // during the reset pulse itself.
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign overflow  = overflow_q;
`ifdef SUB_SEQ_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

    // Single shared byte datapath. The borrow is bit 8 of a 9-bit subtract,
    // so 0x00 - 0xFF - 1 correctly yields a borrow.
    always_comb begin
        a_byte = a_q[{idx_q, 3'b000} +: 8];
        b_byte = b_q[{idx_q, 3'b000} +: 8];
        d9     = {1'b0, a_byte} - {1'b0, b_byte} - {8'd0, borrow_q};
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        borrow_d   = borrow_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        overflow_d = overflow_q;
`ifdef SUB_SEQ_ZERO_FLAG_EN
        zero_acc_d = zero_acc_q;
        zero_d     = zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d        = a;
                    b_d        = b;
                    borrow_d   = bin;
                    idx_d      = '0;
                    diff_d     = '0;
                    bout_d     = 1'b0;
                    overflow_d = 1'b0;
`ifdef SUB_SEQ_ZERO_FLAG_EN
                    zero_acc_d = 1'b1;
                    zero_d     = 1'b0;
`endif
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                diff_d[{idx_q, 3'b000} +: 8] = d9[7:0];
                borrow_d = d9[8];
`ifdef SUB_SEQ_ZERO_FLAG_EN
                zero_acc_d = zero_acc_q && (d9[7:0] == 8'd0);
`endif
                if (idx_q == LAST_IDX) begin
                    // Signed overflow: operand signs differ and the result
                    // sign differs from the minuend sign.
                    bout_d     = d9[8];
                    overflow_d = (a_q[W-1] ^ b_q[W-1]) & (d9[7] ^ a_q[W-1]);
`ifdef SUB_SEQ_ZERO_FLAG_EN
                    zero_d     = zero_acc_q && (d9[7:0] == 8'd0);
`endif
                    idx_d      = '0;
                    state_d    = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            borrow_q   <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef SUB_SEQ_ZERO_FLAG_EN
            zero_acc_q <= 1'b0;
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            borrow_q   <= borrow_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            overflow_q <= overflow_d;
`ifdef SUB_SEQ_ZERO_FLAG_EN
            zero_acc_q <= zero_acc_d;
            zero_q     <= zero_d;
`endif
        end
    end

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// tb/tb_sub_seq_ctrl.sv - scoreboard bench for sub_seq_ctrl (NBYTES=4)

module tb_sub_seq_ctrl;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         overflow;
    logic         busy;
`ifdef SUB_SEQ_ZERO_FLAG_EN
    logic         zero;
`endif

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;

    always #5 clk = ~clk;

    sub_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .overflow  (overflow),
`ifdef SUB_SEQ_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(diff), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_diff", 64'(diff), 64'(e.diff));
                    chk("sb_bout", 64'(bout), 64'(e.bout));
                    chk("sb_ovf", 64'(overflow), 64'(e.ovf));
`ifdef SUB_SEQ_ZERO_FLAG_EN
                    chk("sb_zero", 64'(zero), 64'(e.zero));
`endif
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                          input logic [W-1:0] ediff, input logic eb, input logic eo,
                          input logic ez, input int hold);
        int cnt;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        bin       = vbin;
        exp_q.push_back('{diff: ediff, bout: eb, ovf: eo, zero: ez});
        @(posedge clk); #1;
        // Scramble inputs mid-RUN; the latched operands must be used.
        in_valid = 1'b0;
        a        = ~va;
        b        = 32'hA5A5_A5A5;
        bin      = ~vbin;
        chk("busy_in_run", 64'(busy), 64'd1);
        chk("in_ready_in_run", 64'(in_ready), 64'd0);
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", 64'(cnt), 64'(NBYTES));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                chk("hold_out_valid", 64'(out_valid), 64'd1);
                chk("hold_diff", 64'(diff), 64'(ediff));
                chk("hold_in_ready", 64'(in_ready), 64'd0);
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("post_out_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_bout", 64'(bout), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        @(posedge clk); #1;

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
        run_op(32'h0000_0000, 32'h0000_00FF, 1'b1, 32'hFFFF_FF00, 1'b1, 1'b0, 1'b0, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
        // 0x7FFFFFFF - (-1): signed overflow, and unsigned a < b.
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 10);

        // Reset two cycles into RUN: pending result must vanish at once.
        in_valid = 1'b1;
        a        = 32'h1111_1111;
        b        = 32'h0000_0000;
        bin      = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("partial_diff", 64'(diff), 64'h0000_1111);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_diff", 64'(diff), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("after_rst_in_ready", 64'(in_ready), 64'd1);

        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("result_count", 64'(n_out), 64'd6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
